// File: rtl/fixdiv.sv
// Sequential signed Q0.18 divider: restoring shift-subtract on magnitudes, one quotient
// bit per cycle plus a round bit, then clamp/round and hold the result until accepted.
module fixdiv #(
    parameter int WIDTH = 19,
    parameter int FRAC  = WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             out_ovf,
    output logic             out_dz,
    output logic [1:0]       fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a/b are only sampled on the in_valid&&in_ready edge, and result/out_ovf/out_dz stay
    // stable from out_valid rising until the out_valid&&out_ready edge.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CW = $clog2(FRAC + 1);
    localparam logic [CW-1:0]    LAST    = CW'(FRAC);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_MAG = MIN_NEG;

    state_t state;
    state_t state_next;

    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    logic             sign_r;
    logic             a_neg_r;
    logic             b_zero_r;
    logic             big_r;
    logic [WIDTH-1:0] bmag_r;
    logic [WIDTH:0]   rem_r;
    logic [FRAC:0]    quo_r;
    logic [CW-1:0]    cnt_r;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             fits;

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;
    logic             dz_next;

    assign accept = in_valid && in_ready;

    // Unsigned W-bit magnitudes: -1.0 becomes exactly 2^FRAC, no asymmetric corner.
    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    assign rem_sh  = {rem_r[WIDTH-1:0], 1'b0};
    assign fits    = rem_sh >= {1'b0, bmag_r};
    assign rem_sub = rem_sh - {1'b0, bmag_r};

    // Round half up: drop the extra quotient bit and add it back as the round increment.
    assign mag = {1'b0, quo_r[FRAC:1]} + {{FRAC{1'b0}}, quo_r[0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt_r == LAST) state_next = FINISH;
            FINISH:  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        fsm_state = state;
    end

    // Clamp priority: divide-by-zero, then |a|>=|b|, then a rounded-up full-scale magnitude.
    always_comb begin
        res_next = sign_r ? -mag : mag;
        ovf_next = 1'b0;
        dz_next  = 1'b0;
        if (b_zero_r) begin
            dz_next  = 1'b1;
            ovf_next = 1'b1;
            res_next = a_neg_r ? MIN_NEG : MAX_POS;
        end else if (big_r) begin
            ovf_next = 1'b1;
            res_next = sign_r ? MIN_NEG : MAX_POS;
        end else if (mag == ONE_MAG) begin
            if (sign_r) begin
                res_next = MIN_NEG;
            end else begin
                ovf_next = 1'b1;
                res_next = MAX_POS;
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_r   <= 1'b0;
            a_neg_r  <= 1'b0;
            b_zero_r <= 1'b0;
            big_r    <= 1'b0;
            bmag_r   <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            cnt_r    <= '0;
            result   <= '0;
            out_ovf  <= 1'b0;
            out_dz   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_r   <= a[WIDTH-1] ^ b[WIDTH-1];
                        a_neg_r  <= a[WIDTH-1];
                        b_zero_r <= (b == '0);
                        big_r    <= (a_mag >= b_mag);
                        bmag_r   <= b_mag;
                        rem_r    <= {1'b0, a_mag};
                        quo_r    <= '0;
                        cnt_r    <= '0;
                        out_ovf  <= 1'b0;
                        out_dz   <= 1'b0;
                    end
                end
                CALC: begin
                    rem_r <= fits ? rem_sub : rem_sh;
                    quo_r <= {quo_r[FRAC-1:0], fits};
                    cnt_r <= cnt_r + CW'(1);
                end
                FINISH: begin
                    result  <= res_next;
                    out_ovf <= ovf_next;
                    out_dz  <= dz_next;
                end
                default: ;
            endcase
        end
    end

endmodule
